// File: rtl/spi_xfer_arb.sv
// Round-robin arbiter sharing one SPI master core among NUM_REQ requesters.
// Grants one requester, loads its length, pulses start and tracks busy until done.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no grant; round-robin pick among pending requests
// START     | one-cycle length load and start pulse to the core
// WAIT_BUSY | waiting for the core to raise busy; start timeout armed
// XFER      | core busy; done pulses on the cycle busy falls
// GAP       | chip select released for max(gap_i,1) cycles; lock regrant
module spi_xfer_arb #(
  parameter int NUM_REQ   = 4,
  parameter int TRL_WIDTH = 16,
  parameter int START_TO  = 15,
  parameter int GAP_WIDTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic [NUM_REQ-1:0]           req_i,
  input  logic [NUM_REQ-1:0]           lock_i,
  input  logic [NUM_REQ*TRL_WIDTH-1:0] trl_i,
  input  logic [GAP_WIDTH-1:0]         gap_i,
  input  logic                         busy_i,
  input  logic                         last_i,
  output logic [NUM_REQ-1:0]           gnt_o,
  output logic [NUM_REQ-1:0]           done_o,
  output logic [NUM_REQ-1:0]           err_o,
  output logic                         trl_valid_o,
  output logic [TRL_WIDTH-1:0]         trl_o,
  output logic                         st_o,
  output logic [NUM_REQ-1:0]           nss_sel_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMO_W = (START_TO > 1) ? $clog2(START_TO) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(START_TO - 1);
  localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    XFER,
    GAP
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       win_q, win_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [TRL_WIDTH-1:0]   trl_q, trl_d;
  logic [GAP_WIDTH-1:0]   gap_q, gap_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;

  logic                   rr_hit;
  logic [IDX_W-1:0]       rr_idx;
  logic [IDX_W-1:0]       cand;
  logic [NUM_REQ-1:0]     win_oh;
  logic [TRL_WIDTH-1:0]   trl_rr;
  logic [TRL_WIDTH-1:0]   trl_win;
  logic [GAP_WIDTH-1:0]   gap_load;
  logic                   granted;
  logic                   unused_last;

  // last_i is informational only; sequencing follows busy_i alone.
  assign unused_last = last_i;

  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    cand   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!rr_hit && req_i[cand]) begin
        rr_hit = 1'b1;
        rr_idx = cand;
      end
    end
  end

  always_comb begin
    win_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_oh[i] = (win_q == IDX_W'(i));
    end
  end

  assign trl_rr   = trl_i[int'(rr_idx) * TRL_WIDTH +: TRL_WIDTH];
  assign trl_win  = trl_i[int'(win_q) * TRL_WIDTH +: TRL_WIDTH];
  assign gap_load = (gap_i == '0) ? GAP_WIDTH'(1) : gap_i;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    trl_d   = trl_q;
    gap_d   = gap_q;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE: begin
        if (rr_hit) begin
          win_d   = rr_idx;
          ptr_d   = rr_idx;
          trl_d   = trl_rr;
          state_d = START;
        end
      end
      START: begin
        tmo_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (busy_i) begin
          state_d = XFER;
        end else if (tmo_q == TMO_LAST) begin
          gap_d   = gap_load;
          state_d = GAP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      XFER: begin
        if (!busy_i) begin
          gap_d   = gap_load;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q > GAP_WIDTH'(1)) begin
          gap_d = gap_q - 1'b1;
        end else begin
          gap_d = '0;
          // Locked owner skips arbitration; pointer stays put.
          if (lock_i[win_q] && req_i[win_q]) begin
            trl_d   = trl_win;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      win_q   <= '0;
      ptr_q   <= PTR_RST;
      trl_q   <= '0;
      gap_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      trl_q   <= trl_d;
      gap_q   <= gap_d;
      tmo_q   <= tmo_d;
    end
  end

  assign granted     = (state_q == START) || (state_q == WAIT_BUSY) || (state_q == XFER);
  assign gnt_o       = granted ? win_oh : '0;
  assign nss_sel_o   = granted ? win_oh : '0;
  assign trl_valid_o = (state_q == START);
  assign st_o        = (state_q == START);
  assign trl_o       = (state_q == START) ? trl_q : '0;
  assign done_o      = ((state_q == XFER) && !busy_i) ? win_oh : '0;
  assign err_o       = ((state_q == WAIT_BUSY) && !busy_i && (tmo_q == TMO_LAST)) ? win_oh : '0;

endmodule

// File: tb/tb_spi_xfer_arb.sv
// Directed bench for spi_xfer_arb: reset, single transfer, round-robin, lock,
// start timeout, reset mid-transfer and request drop.
module tb_spi_xfer_arb;
  localparam int NR  = 4;
  localparam int TW  = 16;
  localparam int STO = 15;
  localparam int GW  = 8;

  logic               clk_i = 1'b0;
  logic               rst_n_i;
  logic [NR-1:0]      req_i;
  logic [NR-1:0]      lock_i;
  logic [NR*TW-1:0]   trl_i;
  logic [GW-1:0]      gap_i;
  logic               busy_i;
  logic               last_i;
  logic [NR-1:0]      gnt_o;
  logic [NR-1:0]      done_o;
  logic [NR-1:0]      err_o;
  logic               trl_valid_o;
  logic [TW-1:0]      trl_o;
  logic               st_o;
  logic [NR-1:0]      nss_sel_o;

  int n_cmp  = 0;
  int n_fail = 0;

  spi_xfer_arb #(.NUM_REQ(NR), .TRL_WIDTH(TW), .START_TO(STO), .GAP_WIDTH(GW)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .req_i(req_i), .lock_i(lock_i), .trl_i(trl_i),
    .gap_i(gap_i), .busy_i(busy_i), .last_i(last_i), .gnt_o(gnt_o), .done_o(done_o),
    .err_o(err_o), .trl_valid_o(trl_valid_o), .trl_o(trl_o), .st_o(st_o),
    .nss_sel_o(nss_sel_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0; req_i = '0; lock_i = '0; busy_i = 1'b0;
    tick(); tick();
    rst_n_i = 1'b1;
    settle();
  endtask

  // Drive a transfer from its START cycle to the following IDLE cycle (g = effective gap).
  task automatic finish_from_start(input int g);
    req_i = '0;
    tick(); busy_i = 1'b1;
    tick(); busy_i = 1'b0;
    repeat (g + 1) tick();
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; req_i = '1; lock_i = '1; busy_i = 1'b1; last_i = 1'b0;
    gap_i = 8'd3; trl_i = {16'hA003, 16'h0020, 16'hA001, 16'hA000};
    tick(); tick(); settle();
    n_cmp++;
    if ({gnt_o, done_o, err_o, trl_valid_o, trl_o, st_o, nss_sel_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got gnt=%b done=%b err=%b st=%b trl=%h want all zero",
               gnt_o, done_o, err_o, st_o, trl_o);
    end
    req_i = '0; lock_i = '0; busy_i = 1'b0; rst_n_i = 1'b1;
    settle();
    n_cmp++;
    if ({gnt_o, nss_sel_o, st_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: got gnt=%b nss=%b st=%b want 0", gnt_o, nss_sel_o, st_o);
    end
  endtask

  task automatic test_single();
    req_i = 4'b0100; settle();
    n_cmp++;
    if ({st_o, gnt_o} !== 5'b0) begin
      n_fail++; $display("FAIL single_idle: got st=%b gnt=%b want 0", st_o, gnt_o);
    end
    tick(); settle();
    n_cmp++;
    if ({st_o, trl_valid_o, trl_o, gnt_o, nss_sel_o} !== {1'b1, 1'b1, 16'h0020, 4'b0100, 4'b0100}) begin
      n_fail++;
      $display("FAIL single_start: got st=%b tv=%b trl=%h gnt=%b nss=%b want 1 1 0020 0100 0100",
               st_o, trl_valid_o, trl_o, gnt_o, nss_sel_o);
    end
    tick(); req_i = '0; busy_i = 1'b1; settle();
    n_cmp++;
    if ({st_o, trl_valid_o, gnt_o, nss_sel_o} !== {2'b00, 4'b0100, 4'b0100}) begin
      n_fail++;
      $display("FAIL single_wait: got st=%b tv=%b gnt=%b nss=%b want 0 0 0100 0100",
               st_o, trl_valid_o, gnt_o, nss_sel_o);
    end
    for (int i = 0; i < 9; i++) begin
      tick(); settle();
      n_cmp++;
      if ({gnt_o, nss_sel_o, done_o} !== {4'b0100, 4'b0100, 4'b0000}) begin
        n_fail++;
        $display("FAIL single_xfer[%0d]: got gnt=%b nss=%b done=%b want 0100 0100 0000",
                 i, gnt_o, nss_sel_o, done_o);
      end
    end
    tick(); busy_i = 1'b0; settle();
    n_cmp++;
    if ({done_o, gnt_o, err_o} !== {4'b0100, 4'b0100, 4'b0000}) begin
      n_fail++;
      $display("FAIL single_done: got done=%b gnt=%b err=%b want 0100 0100 0000", done_o, gnt_o, err_o);
    end
    req_i = 4'b0001;
    for (int g = 1; g <= 3; g++) begin
      tick(); settle();
      n_cmp++;
      if ({nss_sel_o, gnt_o, st_o, done_o} !== '0) begin
        n_fail++;
        $display("FAIL single_gap[%0d]: got nss=%b gnt=%b st=%b done=%b want 0", g, nss_sel_o, gnt_o, st_o, done_o);
      end
    end
    tick(); settle();
    n_cmp++;
    if ({st_o, gnt_o} !== 5'b0) begin
      n_fail++; $display("FAIL single_idle_after_gap: got st=%b gnt=%b want 0", st_o, gnt_o);
    end
    tick(); settle();
    n_cmp++;
    if ({st_o, gnt_o, trl_o} !== {1'b1, 4'b0001, 16'hA000}) begin
      n_fail++;
      $display("FAIL single_next_start: got st=%b gnt=%b trl=%h want 1 0001 a000", st_o, gnt_o, trl_o);
    end
    finish_from_start(3);
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] exp_g;
    do_reset();
    gap_i = 8'd0; req_i = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      exp_g = 4'(1 << (t % 4));
      tick(); settle();
      n_cmp++;
      if ({st_o, gnt_o} !== {1'b1, exp_g}) begin
        n_fail++; $display("FAIL rr_start[%0d]: got st=%b gnt=%b want 1 %b", t, st_o, gnt_o, exp_g);
      end
      tick(); busy_i = 1'b1;
      tick(); busy_i = 1'b0; settle();
      n_cmp++;
      if (done_o !== exp_g) begin
        n_fail++; $display("FAIL rr_done[%0d]: got %b want %b", t, done_o, exp_g);
      end
      tick(); settle();
      n_cmp++;
      if ({gnt_o, nss_sel_o, st_o} !== '0) begin
        n_fail++; $display("FAIL rr_gap[%0d]: got gnt=%b nss=%b st=%b want 0", t, gnt_o, nss_sel_o, st_o);
      end
      tick();
      if (t == 4) req_i = '0;
      settle();
      n_cmp++;
      if ({gnt_o, st_o} !== '0) begin
        n_fail++; $display("FAIL rr_idle[%0d]: got gnt=%b st=%b want 0", t, gnt_o, st_o);
      end
    end
  endtask

  task automatic test_lock();
    do_reset();
    gap_i = 8'd0; req_i = 4'b0011; lock_i = 4'b0001;
    trl_i[15:0] = 16'h0100; trl_i[31:16] = 16'hB001;
    for (int t = 0; t < 3; t++) begin
      tick(); settle();
      n_cmp++;
      if ({st_o, gnt_o, trl_o} !== {1'b1, 4'b0001, 16'(16'h0100 + t)}) begin
        n_fail++;
        $display("FAIL lock_start[%0d]: got st=%b gnt=%b trl=%h want 1 0001 %h", t, st_o, gnt_o, trl_o, 16'h0100 + t);
      end
      tick(); busy_i = 1'b1;
      tick(); busy_i = 1'b0; settle();
      n_cmp++;
      if (done_o !== 4'b0001) begin
        n_fail++; $display("FAIL lock_done[%0d]: got %b want 0001", t, done_o);
      end
      trl_i[15:0] = 16'(16'h0101 + t);
      if (t == 2) lock_i = '0;
      tick(); settle();
      n_cmp++;
      if ({gnt_o, st_o} !== '0) begin
        n_fail++; $display("FAIL lock_gap[%0d]: got gnt=%b st=%b want 0", t, gnt_o, st_o);
      end
    end
    tick(); settle();
    n_cmp++;
    if ({st_o, gnt_o} !== '0) begin
      n_fail++; $display("FAIL lock_idle: got st=%b gnt=%b want 0", st_o, gnt_o);
    end
    tick(); settle();
    n_cmp++;
    if ({st_o, gnt_o, trl_o} !== {1'b1, 4'b0010, 16'hB001}) begin
      n_fail++; $display("FAIL lock_release: got st=%b gnt=%b trl=%h want 1 0010 b001", st_o, gnt_o, trl_o);
    end
    finish_from_start(1);
  endtask

  task automatic test_timeout();
    gap_i = 8'd2; req_i = 4'b0010;
    tick(); settle();
    n_cmp++;
    if ({st_o, gnt_o} !== {1'b1, 4'b0010}) begin
      n_fail++; $display("FAIL tmo_start: got st=%b gnt=%b want 1 0010", st_o, gnt_o);
    end
    req_i = '0; busy_i = 1'b0;
    for (int c = 1; c <= STO; c++) begin
      tick(); settle();
      n_cmp++;
      if (c < STO) begin
        if ({err_o, done_o, gnt_o} !== {4'b0000, 4'b0000, 4'b0010}) begin
          n_fail++; $display("FAIL tmo_wait[%0d]: got err=%b done=%b gnt=%b want 0000 0000 0010", c, err_o, done_o, gnt_o);
        end
      end else begin
        if ({err_o, done_o, gnt_o} !== {4'b0010, 4'b0000, 4'b0010}) begin
          n_fail++; $display("FAIL tmo_err: got err=%b done=%b gnt=%b want 0010 0000 0010", err_o, done_o, gnt_o);
        end
      end
    end
    req_i = 4'b0100;
    for (int g = 1; g <= 3; g++) begin
      tick(); settle();
      n_cmp++;
      if ({st_o, gnt_o, err_o, done_o, nss_sel_o} !== '0) begin
        n_fail++;
        $display("FAIL tmo_gap_idle[%0d]: got st=%b gnt=%b err=%b done=%b nss=%b want 0", g, st_o, gnt_o, err_o, done_o, nss_sel_o);
      end
    end
    tick(); settle();
    n_cmp++;
    if ({st_o, gnt_o} !== {1'b1, 4'b0100}) begin
      n_fail++; $display("FAIL tmo_next: got st=%b gnt=%b want 1 0100", st_o, gnt_o);
    end
    finish_from_start(2);
  endtask

  task automatic test_reset_mid();
    gap_i = 8'd1; req_i = 4'b0001;
    tick(); settle();
    n_cmp++;
    if ({st_o, gnt_o} !== {1'b1, 4'b0001}) begin
      n_fail++; $display("FAIL rstmid_start: got st=%b gnt=%b want 1 0001", st_o, gnt_o);
    end
    req_i = '0;
    tick(); busy_i = 1'b1;
    tick(); settle();
    n_cmp++;
    if (gnt_o !== 4'b0001) begin
      n_fail++; $display("FAIL rstmid_xfer: got gnt=%b want 0001", gnt_o);
    end
    rst_n_i = 1'b0;
    tick(); settle();
    n_cmp++;
    if ({gnt_o, done_o, err_o, trl_valid_o, trl_o, st_o, nss_sel_o} !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs: got gnt=%b done=%b nss=%b st=%b want 0", gnt_o, done_o, nss_sel_o, st_o);
    end
    rst_n_i = 1'b1; busy_i = 1'b0; req_i = 4'b1001;
    tick(); settle();
    n_cmp++;
    if ({st_o, gnt_o} !== {1'b1, 4'b0001}) begin
      n_fail++; $display("FAIL rstmid_ptr: got st=%b gnt=%b want 1 0001", st_o, gnt_o);
    end
    finish_from_start(1);
  endtask

  task automatic test_drop_req();
    gap_i = 8'd1; req_i = 4'b0100; lock_i = 4'b0100;
    tick(); settle();
    n_cmp++;
    if ({st_o, gnt_o} !== {1'b1, 4'b0100}) begin
      n_fail++; $display("FAIL drop_start: got st=%b gnt=%b want 1 0100", st_o, gnt_o);
    end
    tick(); req_i = '0; busy_i = 1'b1; settle();
    n_cmp++;
    if (nss_sel_o !== 4'b0100) begin
      n_fail++; $display("FAIL drop_wait: got nss=%b want 0100", nss_sel_o);
    end
    tick(); busy_i = 1'b0; settle();
    n_cmp++;
    if (done_o !== 4'b0100) begin
      n_fail++; $display("FAIL drop_done: got %b want 0100", done_o);
    end
    tick(); tick(); tick(); settle();
    n_cmp++;
    if ({st_o, gnt_o} !== '0) begin
      n_fail++; $display("FAIL drop_no_regrant: got st=%b gnt=%b want 0", st_o, gnt_o);
    end
    lock_i = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_timeout();
    test_reset_mid();
    test_drop_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
